// File: rtl/axi_warb_pkg.sv
// ---------------------------------------------------------------------------
// axi_warb_pkg
// Shared types and helpers for the crossbar write-path arbiter.
//  - burst_e / resp_e : AXI burst and response encodings
//  - aw_req_t, w_req_t, b_resp_t : beat layouts for the default configuration
//    (2 masters, 4-bit upstream ID, 64-bit address and data)
//  - IDX_WIDTH / ID_OUT : master-index width and widened downstream ID width
//    for that default configuration
//  - idx_bits() : index width for an arbitrary master/entry count (min 1)
// ---------------------------------------------------------------------------
package axi_warb_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam int MASTER_NUM_DFLT = 2;
    localparam int ID_WIDTH_DFLT   = 4;
    localparam int ADDR_WIDTH_DFLT = 64;
    localparam int DATA_WIDTH_DFLT = 64;
    localparam int IDX_WIDTH       = $clog2(MASTER_NUM_DFLT);
    localparam int ID_OUT          = ID_WIDTH_DFLT + IDX_WIDTH;

    typedef struct packed {
        logic [ID_WIDTH_DFLT-1:0]   id;
        logic [ADDR_WIDTH_DFLT-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        burst_e                     burst;
    } aw_req_t;

    typedef struct packed {
        logic [DATA_WIDTH_DFLT-1:0]   data;
        logic [DATA_WIDTH_DFLT/8-1:0] strb;
        logic                         last;
    } w_req_t;

    typedef struct packed {
        logic [ID_OUT-1:0] id;
        resp_e             resp;
    } b_resp_t;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_warb_order_fifo.sv
// ---------------------------------------------------------------------------
// axi_warb_order_fifo
// Records the master index of every accepted AW so W beats can be steered in
// AW-grant order.
// Ports:
//  clk, rst          clock, asynchronous active-high reset
//  push, push_data   write one index (ignored when full)
//  pop               drop the head entry (ignored when empty)
//  head              current head index (valid when !empty)
//  full, empty       occupancy flags
// The head is read combinationally: the W mux needs it in the same cycle the
// entry becomes visible, and the array is only a handful of entries deep.
// ---------------------------------------------------------------------------
module axi_warb_order_fifo
    import axi_warb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = idx_bits(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    // One extra wrap bit distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
// Shares one downstream AXI write port (AW/W/B) between MASTER_NUM masters.
//  - AW: round-robin arbitration, winner index prefixed onto AWID
//  - W : steered from the master at the head of the AW-order FIFO
//  - B : routed back by the ID prefix (purely combinational)
// Ports:
//  clk, rst                         clock, asynchronous active-high reset
//  m_aw_* / m_w_* / m_b_*           per-master upstream channels
//  s_aw_* / s_w_* / s_b_*           downstream channels (ID widened)
// Build option: define AXI_WARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no rotating pointer) instead of round-robin.
// ---------------------------------------------------------------------------
module axi_write_arbiter
    import axi_warb_pkg::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MASTER_NUM-1:0]                 m_aw_valid,
    output logic [MASTER_NUM-1:0]                 m_aw_ready,
    input  logic [MASTER_NUM-1:0][ID_WIDTH-1:0]   m_aw_id,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_aw_addr,
    input  logic [MASTER_NUM-1:0][7:0]            m_aw_len,
    input  logic [MASTER_NUM-1:0][2:0]            m_aw_size,
    input  logic [MASTER_NUM-1:0][1:0]            m_aw_burst,
    input  logic [MASTER_NUM-1:0]                 m_w_valid,
    output logic [MASTER_NUM-1:0]                 m_w_ready,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_w_data,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH/8-1:0] m_w_strb,
    input  logic [MASTER_NUM-1:0]                 m_w_last,
    output logic [MASTER_NUM-1:0]                 m_b_valid,
    input  logic [MASTER_NUM-1:0]                 m_b_ready,
    output logic [ID_WIDTH-1:0]                   m_b_id,
    output logic [1:0]                            m_b_resp,
    output logic                                  s_aw_valid,
    input  logic                                  s_aw_ready,
    output logic [ID_WIDTH+idx_bits(MASTER_NUM)-1:0] s_aw_id,
    output logic [ADDR_WIDTH-1:0]                 s_aw_addr,
    output logic [7:0]                            s_aw_len,
    output logic [2:0]                            s_aw_size,
    output logic [1:0]                            s_aw_burst,
    output logic                                  s_w_valid,
    input  logic                                  s_w_ready,
    output logic [DATA_WIDTH-1:0]                 s_w_data,
    output logic [DATA_WIDTH/8-1:0]               s_w_strb,
    output logic                                  s_w_last,
    input  logic                                  s_b_valid,
    output logic                                  s_b_ready,
    input  logic [ID_WIDTH+idx_bits(MASTER_NUM)-1:0] s_b_id,
    input  logic [1:0]                            s_b_resp
);

    localparam int             IW       = idx_bits(MASTER_NUM);
    localparam int             OW       = ID_WIDTH + IW;
    localparam logic [IW-1:0]  LAST_IDX = IW'(MASTER_NUM - 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_e;

    state_e        state_reg, state_next;
    logic [IW-1:0] winner_reg, winner_next;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick;
    logic          pick_found;
    logic          aw_valid;
    logic          aw_accept;
    logic          fifo_full, fifo_empty;
    logic [IW-1:0] head_idx;
    logic          w_active;
    logic          w_pop;
    logic [IW-1:0] b_idx;
    logic          b_known;

    // ------------------------------------------------------------------ pick
`ifdef AXI_WARB_FIXED_PRIO_EN
    always_comb begin
        pick       = '0;
        pick_found = |m_aw_valid;
        // Scan downwards so the lowest valid index is the last one written.
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (m_aw_valid[IW'(i)]) pick = IW'(i);
        end
    end
`else
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] cand;

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            cand = IW'((int'(ptr_reg) + i) % MASTER_NUM);
            if (!pick_found && m_aw_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (aw_accept) begin
            ptr_reg <= (winner == LAST_IDX) ? '0 : winner + IW'(1);
        end
    end
`endif

    // ------------------------------------------------------------- AW FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            winner_reg <= '0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        winner      = winner_reg;
        aw_valid    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Zero-latency grant: the combinational winner drives s_aw_*
                // directly; only an unaccepted request is latched.
                winner   = pick;
                aw_valid = pick_found && !fifo_full;
                if (aw_valid && !s_aw_ready) begin
                    state_next  = ST_GRANT;
                    winner_next = pick;
                end
            end
            ST_GRANT: begin
                // No push happens while waiting, so the FIFO cannot fill here.
                aw_valid = !fifo_full;
                if (s_aw_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Keep the zero-latency path quiet while reset is held.
        if (rst) aw_valid = 1'b0;
    end

    assign aw_accept  = aw_valid && s_aw_ready;
    assign s_aw_valid = aw_valid;
    assign s_aw_id    = {winner, m_aw_id[winner]};
    assign s_aw_addr  = m_aw_addr[winner];
    assign s_aw_len   = m_aw_len[winner];
    assign s_aw_size  = m_aw_size[winner];
    assign s_aw_burst = m_aw_burst[winner];

    // ---------------------------------------------------- W order and mux
    axi_warb_order_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IW)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_accept),
        .push_data (winner),
        .pop       (w_pop),
        .head      (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign w_active  = !fifo_empty;
    assign s_w_valid = w_active && m_w_valid[head_idx];
    assign s_w_data  = m_w_data[head_idx];
    assign s_w_strb  = m_w_strb[head_idx];
    assign s_w_last  = m_w_last[head_idx];
    assign w_pop     = s_w_valid && s_w_ready && s_w_last;

    // ------------------------------------------------------------ B route
    assign b_idx     = s_b_id[OW-1:ID_WIDTH];
    assign b_known   = (int'(b_idx) < MASTER_NUM);
    assign m_b_id    = s_b_id[ID_WIDTH-1:0];
    assign m_b_resp  = s_b_resp;
    // Responses carrying an unknown prefix are sunk so the slave never stalls.
    assign s_b_ready = !rst && (b_known ? m_b_ready[b_idx] : 1'b1);

    // ------------------------------------------------- per-master outputs
    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_master
        assign m_aw_ready[gi] = aw_accept && (winner == IW'(gi));
        assign m_w_ready[gi]  = w_active && s_w_ready && (head_idx == IW'(gi));
        assign m_b_valid[gi]  = !rst && s_b_valid && (b_idx == IW'(gi));
    end

endmodule
